// File: rtl/alu_seq_ctrl.sv
// Control sequencer for the pipelined CPU datapath: decodes fetched instructions into
// single-cycle registered enables/selects, runs multi-cycle multiply and jump interlock/flush.
module alu_seq_ctrl #(
    parameter  int DATA_W  = 4,
    parameter  int GPR_N   = 4,
    parameter  int MUL_CYC = DATA_W,
    localparam int GPR_AW  = $clog2(GPR_N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W+3:0] instr,
    output logic              instr_ready,
    input  logic              carry_in,
    output logic              load_A,
    output logic              load_B,
    output logic              load_OUT,
    output logic              load_GPR,
    output logic [GPR_AW-1:0] gpr_sel,
    output logic [1:0]        mux_sel,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] imm_out,
    output logic              mul_step,
    output logic              jump,
    output logic [DATA_W-1:0] jump_addr,
    output logic              busy
);
    localparam int CNT_W = $clog2(MUL_CYC + 1);

    localparam logic [3:0] OP_MOVAI = 4'h0, OP_MOVAB = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOVBI = 4'h4, OP_MOVBA = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7;
    localparam logic [3:0] OP_OUTA  = 4'h8, OP_OUTI  = 4'h9, OP_ST   = 4'hA, OP_LD   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC, OP_JNC   = 4'hD, OP_JMP  = 4'hE;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MUL   = 2'd1,
        ST_JWAIT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic                r_flag, w_flag;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [DATA_W-1:0]   r_tgt, w_tgt;
    logic                r_load_a, r_load_b, r_load_out, r_load_gpr, r_mul_step, r_jump;
    logic                w_load_a, w_load_b, w_load_out, w_load_gpr, w_mul_step, w_jump;
    logic [GPR_AW-1:0]   r_gpr, w_gpr;
    logic [1:0]          r_mux, w_mux;
    logic [2:0]          r_alu, w_alu;
    logic [DATA_W-1:0]   r_imm, w_imm, r_jaddr, w_jaddr;
    logic                w_ready, w_accept;
    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm_in;

    assign w_op     = instr[DATA_W+3:DATA_W];
    assign w_imm_in = instr[DATA_W-1:0];
    assign w_ready  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign w_accept = instr_valid && w_ready;

    // Next-state and next-output decode; every registered output defaults to idle.
    always_comb begin
        w_state    = r_state;
        w_flag     = 1'b0;
        w_cnt      = r_cnt;
        w_tgt      = r_tgt;
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        w_load_out = 1'b0;
        w_load_gpr = 1'b0;
        w_mul_step = 1'b0;
        w_jump     = 1'b0;
        w_gpr      = {GPR_AW{1'b0}};
        w_mux      = 2'b00;
        w_alu      = 3'b000;
        w_imm      = {DATA_W{1'b0}};
        w_jaddr    = r_jaddr;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    case (w_op)
                        OP_MOVAI: begin w_load_a = 1'b1; w_imm = w_imm_in; end
                        OP_MOVAB: begin w_load_a = 1'b1; w_mux = 2'b01; end
                        OP_ADD:   begin w_load_a = 1'b1; w_mux = 2'b10; w_alu = 3'b001; w_flag = 1'b1; end
                        OP_SUB:   begin w_load_a = 1'b1; w_mux = 2'b10; w_alu = 3'b010; w_flag = 1'b1; end
                        OP_MOVBI: begin w_load_b = 1'b1; w_imm = w_imm_in; end
                        OP_MOVBA: begin w_load_b = 1'b1; w_mux = 2'b10; end
                        OP_AND:   begin w_load_a = 1'b1; w_mux = 2'b10; w_alu = 3'b011; end
                        OP_OR:    begin w_load_a = 1'b1; w_mux = 2'b10; w_alu = 3'b100; end
                        OP_OUTA:  begin w_load_out = 1'b1; w_mux = 2'b10; end
                        OP_OUTI:  begin w_load_out = 1'b1; w_imm = w_imm_in; end
                        OP_ST:    begin w_load_gpr = 1'b1; w_mux = 2'b10; w_gpr = w_imm_in[GPR_AW-1:0]; end
                        OP_LD:    begin w_load_a = 1'b1; w_mux = 2'b11; w_gpr = w_imm_in[GPR_AW-1:0]; end
                        OP_MUL: begin
                            w_state    = ST_MUL;
                            w_cnt      = CNT_W'(1);
                            w_mul_step = 1'b1;
                            w_mux      = 2'b10;
                            w_alu      = 3'b101;
                        end
                        OP_JNC: begin
                            // A pending ADD/SUB carry is not yet valid: wait one cycle for it.
                            if (r_flag) begin
                                w_state = ST_JWAIT;
                                w_tgt   = w_imm_in;
                            end else if (!carry_in) begin
                                w_state = ST_FLUSH;
                                w_jump  = 1'b1;
                                w_jaddr = w_imm_in;
                            end else begin
                                w_state = ST_RUN;
                            end
                        end
                        OP_JMP: begin
                            w_state = ST_FLUSH;
                            w_jump  = 1'b1;
                            w_jaddr = w_imm_in;
                        end
                        default: w_state = ST_RUN;
                    endcase
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_MUL: begin
                // r_cnt counts steps already issued; the last step also loads A.
                if (r_cnt == CNT_W'(MUL_CYC)) begin
                    w_state = ST_RUN;
                    w_cnt   = {CNT_W{1'b0}};
                end else begin
                    w_mul_step = 1'b1;
                    w_mux      = 2'b10;
                    w_alu      = 3'b101;
                    w_load_a   = (r_cnt == CNT_W'(MUL_CYC - 1));
                    w_cnt      = r_cnt + CNT_W'(1);
                end
            end
            ST_JWAIT: begin
                if (!carry_in) begin
                    w_state = ST_FLUSH;
                    w_jump  = 1'b1;
                    w_jaddr = r_tgt;
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_accept) begin
                    w_state = ST_RUN;
                end else begin
                    w_state = ST_FLUSH;
                end
            end
            default: w_state = ST_RUN;
        endcase
    end

    // State, sequencing bookkeeping and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_flag     <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
            r_tgt      <= {DATA_W{1'b0}};
            r_load_a   <= 1'b0;
            r_load_b   <= 1'b0;
            r_load_out <= 1'b0;
            r_load_gpr <= 1'b0;
            r_mul_step <= 1'b0;
            r_jump     <= 1'b0;
            r_gpr      <= {GPR_AW{1'b0}};
            r_mux      <= 2'b00;
            r_alu      <= 3'b000;
            r_imm      <= {DATA_W{1'b0}};
            r_jaddr    <= {DATA_W{1'b0}};
        end else begin
            r_state    <= w_state;
            r_flag     <= w_flag;
            r_cnt      <= w_cnt;
            r_tgt      <= w_tgt;
            r_load_a   <= w_load_a;
            r_load_b   <= w_load_b;
            r_load_out <= w_load_out;
            r_load_gpr <= w_load_gpr;
            r_mul_step <= w_mul_step;
            r_jump     <= w_jump;
            r_gpr      <= w_gpr;
            r_mux      <= w_mux;
            r_alu      <= w_alu;
            r_imm      <= w_imm;
            r_jaddr    <= w_jaddr;
        end
    end

    assign instr_ready = w_ready;
    assign busy        = (r_state != ST_RUN);
    assign load_A      = r_load_a;
    assign load_B      = r_load_b;
    assign load_OUT    = r_load_out;
    assign load_GPR    = r_load_gpr;
    assign gpr_sel     = r_gpr;
    assign mux_sel     = r_mux;
    assign alu_op      = r_alu;
    assign imm_out     = r_imm;
    assign mul_step    = r_mul_step;
    assign jump        = r_jump;
    assign jump_addr   = r_jaddr;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (DATA_W=4, GPR_N=4, MUL_CYC=4).
module tb_alu_seq_ctrl;
    logic       clock;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       carry_in;
    logic       load_A, load_B, load_OUT, load_GPR;
    logic [1:0] gpr_sel;
    logic [1:0] mux_sel;
    logic [2:0] alu_op;
    logic [3:0] imm_out;
    logic       mul_step;
    logic       jump;
    logic [3:0] jump_addr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.DATA_W(4), .GPR_N(4), .MUL_CYC(4)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .carry_in(carry_in),
        .load_A(load_A), .load_B(load_B), .load_OUT(load_OUT), .load_GPR(load_GPR),
        .gpr_sel(gpr_sel), .mux_sel(mux_sel), .alu_op(alu_op), .imm_out(imm_out),
        .mul_step(mul_step), .jump(jump), .jump_addr(jump_addr), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {load_A,load_B,load_OUT,load_GPR, mux_sel, alu_op, imm_out, mul_step, jump}
    function automatic logic [31:0] obs_v();
        return {17'd0, load_A, load_B, load_OUT, load_GPR, mux_sel, alu_op, imm_out, mul_step, jump};
    endfunction

    function automatic logic [31:0] ev(input logic [3:0] ld, input logic [1:0] mux,
                                       input logic [2:0] alu, input logic [3:0] imm,
                                       input logic ms, input logic j);
        return {17'd0, ld, mux, alu, imm, ms, j};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [3:0] imm);
        instr_valid = 1'b1;
        instr       = {op, imm};
    endtask

    initial begin
        reset = 1'b0; instr_valid = 1'b0; instr = 8'h00; carry_in = 1'b0;
        #3;
        chk("reset_outs", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a multiply.
        issue(4'hC, 4'h0); tick(); instr_valid = 1'b0;
        chk("mul_pre_rst", obs_v(), ev(4'b0000, 2'b10, 3'b101, 4'h0, 1'b1, 1'b0));
        tick();
        reset = 1'b0; #2;
        chk("midmul_rst_outs", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("midmul_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("midmul_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        issue(4'h0, 4'h5); tick(); instr_valid = 1'b0;
        chk("movai_5", obs_v(), ev(4'b1000, 2'b00, 3'b000, 4'h5, 1'b0, 1'b0));
        tick();
        chk("movai_pulse_end", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));

        // Back-to-back ADD / SUB.
        issue(4'h2, 4'h0); tick();
        chk("add", obs_v(), ev(4'b1000, 2'b10, 3'b001, 4'h0, 1'b0, 1'b0));
        issue(4'h3, 4'h0); tick(); instr_valid = 1'b0;
        chk("sub", obs_v(), ev(4'b1000, 2'b10, 3'b010, 4'h0, 1'b0, 1'b0));
        tick();

        // Multiply: MOVBI waits on the handshake for the whole sequence.
        issue(4'hC, 4'h0); tick();
        issue(4'h4, 4'h7);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("mul_step_t%0d", i), obs_v(), ev(4'b0000, 2'b10, 3'b101, 4'h0, 1'b1, 1'b0));
            chk($sformatf("mul_ready_t%0d", i), {30'd0, instr_ready, busy}, 32'd1);
            tick();
        end
        chk("mul_final", obs_v(), ev(4'b1000, 2'b10, 3'b101, 4'h0, 1'b1, 1'b0));
        chk("mul_final_ready", {30'd0, instr_ready, busy}, 32'd1);
        tick();
        chk("mul_done", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("mul_done_ready", {30'd0, instr_ready, busy}, 32'd2);
        tick(); instr_valid = 1'b0;
        chk("movbi_after_mul", obs_v(), ev(4'b0100, 2'b00, 3'b000, 4'h7, 1'b0, 1'b0));

        // JNC interlocked on a pending ADD carry, carry clear -> jump.
        issue(4'h2, 4'h0); tick();
        issue(4'hD, 4'h9); carry_in = 1'b0; tick(); instr_valid = 1'b0;
        chk("jwait_outs", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("jwait_ready_busy", {30'd0, instr_ready, busy}, 32'd1);
        carry_in = 1'b0; tick();
        chk("jnc_wait_jump", {27'd0, jump, jump_addr}, {27'd0, 1'b1, 4'h9});
        chk("jnc_wait_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("jump_hold", {27'd0, jump, jump_addr}, {27'd0, 1'b0, 4'h9});
        chk("flush_idle_busy", {30'd0, instr_ready, busy}, 32'd3);
        issue(4'hF, 4'h0); tick(); instr_valid = 1'b0;
        chk("flush_exit_busy", {31'd0, busy}, 32'd0);

        // Same interlock, carry set in the wait cycle -> no jump.
        issue(4'h2, 4'h0); tick();
        issue(4'hD, 4'h5); carry_in = 1'b0; tick(); instr_valid = 1'b0;
        carry_in = 1'b1; tick();
        chk("jnc_wait_nojump", {27'd0, jump, jump_addr}, {27'd0, 1'b0, 4'h9});
        chk("jnc_wait_nojump_busy", {31'd0, busy}, 32'd0);

        // JNC without a pending flag samples carry immediately.
        issue(4'hD, 4'h3); carry_in = 1'b0; tick();
        issue(4'hF, 4'h0);
        chk("jnc_direct_jump", {27'd0, jump, jump_addr}, {27'd0, 1'b1, 4'h3});
        tick();
        issue(4'hD, 4'h4); carry_in = 1'b1; tick(); instr_valid = 1'b0;
        chk("jnc_direct_nojump", {27'd0, jump, jump_addr, busy}, {26'd0, 1'b0, 4'h3, 1'b0});

        // JMP, wrong-path OUTI flushed, MOVBI issues.
        issue(4'hE, 4'hC); tick();
        chk("jmp", {27'd0, jump, jump_addr}, {27'd0, 1'b1, 4'hC});
        issue(4'h9, 4'h3); tick();
        chk("outi_flushed", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        issue(4'h4, 4'h7); tick();
        chk("movbi_after_flush", obs_v(), ev(4'b0100, 2'b00, 3'b000, 4'h7, 1'b0, 1'b0));

        // GPR access and misc decodes.
        issue(4'hA, 4'h6); tick();
        chk("st", obs_v(), ev(4'b0001, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("st_sel", {30'd0, gpr_sel}, 32'd2);
        issue(4'hB, 4'h1); tick();
        chk("ld", obs_v(), ev(4'b1000, 2'b11, 3'b000, 4'h0, 1'b0, 1'b0));
        chk("ld_sel", {30'd0, gpr_sel}, 32'd1);
        issue(4'hF, 4'h0); tick();
        chk("nop", obs_v(), ev(4'b0000, 2'b00, 3'b000, 4'h0, 1'b0, 1'b0));
        issue(4'h7, 4'h0); tick();
        chk("or", obs_v(), ev(4'b1000, 2'b10, 3'b100, 4'h0, 1'b0, 1'b0));
        issue(4'h1, 4'h0); tick();
        chk("movab", obs_v(), ev(4'b1000, 2'b01, 3'b000, 4'h0, 1'b0, 1'b0));
        issue(4'h8, 4'h0); tick(); instr_valid = 1'b0;
        chk("outa", obs_v(), ev(4'b0010, 2'b10, 3'b000, 4'h0, 1'b0, 1'b0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
